// File: rtl/input_port_star.sv
// input_port_star: star-router input buffer; FIFO plus per-packet route latch in front of the switch.
module input_port_star #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] rc_flit,
  input  logic              rc_e1,
  input  logic              rc_e2,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_e1,
  output logic              out_e2,
  output logic [PTR_W:0]    fifo_count,
  output logic              err_stray,
  output logic              err_route
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
  state_t            state_q, state_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              e1_q, e1_d, e2_q, e2_d;
  logic              err_stray_q, err_stray_d, err_route_q, err_route_d;
  logic              empty, wr, pop, is_hdr, is_tail;
  logic [FLIT_W-1:0] head;
  assign head       = mem_q[rd_ptr_q];
  assign is_hdr     = head[FLIT_W-1];
  // type 01 and 11 both close a packet
  assign is_tail    = head[FLIT_W-2];
  assign empty      = count_q == '0;
  assign in_ready   = count_q != (PTR_W+1)'(DEPTH);
  assign wr         = in_valid && in_ready;
  assign out_valid  = state_q == ACTIVE && !empty;
  assign out_flit   = head;
  assign rc_flit    = head;
  assign out_e1     = e1_q;
  assign out_e2     = e2_q;
  assign fifo_count = count_q;
  assign err_stray  = err_stray_q;
  assign err_route  = err_route_q;
  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    err_stray_d = 1'b0;
    err_route_d = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        if (!is_hdr) begin
          pop         = 1'b1;
          err_stray_d = 1'b1;
        end else if (rc_e1 ^ rc_e2) begin
          e1_d    = rc_e1;
          e2_d    = rc_e2;
          state_d = ACTIVE;
        end else begin
          err_route_d = 1'b1;
          state_d     = DROP;
        end
      end
      ACTIVE: begin
        pop = out_valid && out_ready;
        if (pop && is_tail) begin
          state_d = IDLE;
          e1_d    = 1'b0;
          e2_d    = 1'b0;
        end
      end
      DROP: begin
        pop     = !empty;
        state_d = pop && is_tail ? IDLE : DROP;
      end
      default: state_d = IDLE;
    endcase
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = in_flit;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      e1_q        <= 1'b0;
      e2_q        <= 1'b0;
      err_stray_q <= 1'b0;
      err_route_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      err_stray_q <= err_stray_d;
      err_route_q <= err_route_d;
    end
  end
endmodule

// File: tb/tb_input_port_star.sv
// tb_input_port_star: directed vectors for input_port_star; outputs sampled on the falling edge.
module tb_input_port_star;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_flit;
  logic        in_valid, in_ready;
  logic [15:0] rc_flit, out_flit;
  logic        rc_e1, rc_e2, out_valid, out_ready, out_e1, out_e2;
  logic [2:0]  fifo_count;
  logic        err_stray, err_route;
  int          errors = 0;
  int          checks = 0;

  input_port_star dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .rc_flit(rc_flit), .rc_e1(rc_e1), .rc_e2(rc_e2), .out_flit(out_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_e1(out_e1), .out_e2(out_e2),
    .fifo_count(fifo_count), .err_stray(err_stray), .err_route(err_route)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; in_flit = '0; in_valid = 1'b0; rc_e1 = 1'b0; rc_e2 = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_e", 16'({out_e1, out_e2}), 16'd0);
    chk("rst_err", 16'({err_stray, err_route}), 16'd0);
    step; rst = 1'b1;
    // single packet to port 2
    rc_e2 = 1'b1; in_flit = 16'h8001; in_valid = 1'b1;
    step;
    chk("t1_count1", 16'(fifo_count), 16'd1);
    chk("t1_ov_idle", 16'(out_valid), 16'd0);
    chk("t1_rc_flit", rc_flit, 16'h8001);
    in_flit = 16'h0055;
    step;
    chk("t1_ov_hdr", 16'(out_valid), 16'd1);
    chk("t1_hdr", out_flit, 16'h8001);
    chk("t1_e", 16'({out_e1, out_e2}), 16'b01);
    in_flit = 16'h4066;
    step;
    chk("t1_body", out_flit, 16'h0055);
    chk("t1_ov_body", 16'(out_valid), 16'd1);
    in_valid = 1'b0;
    step;
    chk("t1_tail", out_flit, 16'h4066);
    chk("t1_ov_tail", 16'(out_valid), 16'd1);
    step;
    chk("t1_ov_end", 16'(out_valid), 16'd0);
    chk("t1_e_end", 16'({out_e1, out_e2}), 16'd0);
    chk("t1_count_end", 16'(fifo_count), 16'd0);
    // backpressure: five flits with the switch stalled
    rc_e1 = 1'b1; rc_e2 = 1'b0; out_ready = 1'b0;
    in_flit = 16'h8004; in_valid = 1'b1;
    step; in_flit = 16'h0001;
    step; in_flit = 16'h0002;
    chk("t2_in_ready3", 16'(in_ready), 16'd1);
    step; in_flit = 16'h0003;
    step;
    chk("t2_full_ready", 16'(in_ready), 16'd0);
    chk("t2_full_count", 16'(fifo_count), 16'd4);
    in_flit = 16'h4005;
    step;
    chk("t2_held_count", 16'(fifo_count), 16'd4);
    chk("t2_head_hdr", out_flit, 16'h8004);
    chk("t2_ov_stall", 16'(out_valid), 16'd1);
    chk("t2_e", 16'({out_e1, out_e2}), 16'b10);
    out_ready = 1'b1;
    step;
    chk("t2_d1", out_flit, 16'h0001);
    chk("t2_ready_back", 16'(in_ready), 16'd1);
    chk("t2_count3", 16'(fifo_count), 16'd3);
    step; in_valid = 1'b0;
    chk("t2_d2", out_flit, 16'h0002);
    chk("t2_count_wp", 16'(fifo_count), 16'd3);
    step;
    chk("t2_d3", out_flit, 16'h0003);
    step;
    chk("t2_d4", out_flit, 16'h4005);
    chk("t2_ov_d4", 16'(out_valid), 16'd1);
    step;
    chk("t2_ov_end", 16'(out_valid), 16'd0);
    chk("t2_e_end", 16'({out_e1, out_e2}), 16'd0);
    chk("t2_count_end", 16'(fifo_count), 16'd0);
    // single-flit packet to port 1
    in_flit = 16'hC003; in_valid = 1'b1;
    step; in_valid = 1'b0;
    chk("t3_ov_idle", 16'(out_valid), 16'd0);
    step;
    chk("t3_ov", 16'(out_valid), 16'd1);
    chk("t3_flit", out_flit, 16'hC003);
    chk("t3_e", 16'({out_e1, out_e2}), 16'b10);
    step;
    chk("t3_ov_end", 16'(out_valid), 16'd0);
    chk("t3_e_end", 16'({out_e1, out_e2}), 16'd0);
    chk("t3_count", 16'(fifo_count), 16'd0);
    // stray body flit while idle
    in_flit = 16'h0012; in_valid = 1'b1;
    step; in_valid = 1'b0;
    chk("t4_count1", 16'(fifo_count), 16'd1);
    chk("t4_stray_pre", 16'(err_stray), 16'd0);
    step;
    chk("t4_stray", 16'(err_stray), 16'd1);
    chk("t4_count0", 16'(fifo_count), 16'd0);
    chk("t4_ov", 16'(out_valid), 16'd0);
    step;
    chk("t4_stray_end", 16'(err_stray), 16'd0);
    chk("t4_route", 16'(err_route), 16'd0);
    // header with no valid route: whole packet dropped
    rc_e1 = 1'b0; rc_e2 = 1'b0;
    in_flit = 16'h8002; in_valid = 1'b1;
    step; in_flit = 16'h0011;
    step; in_flit = 16'h4022;
    chk("t5_route", 16'(err_route), 16'd1);
    chk("t5_ov_a", 16'(out_valid), 16'd0);
    chk("t5_count2", 16'(fifo_count), 16'd2);
    step; in_valid = 1'b0;
    chk("t5_route_end", 16'(err_route), 16'd0);
    chk("t5_ov_b", 16'(out_valid), 16'd0);
    chk("t5_count2b", 16'(fifo_count), 16'd2);
    step;
    chk("t5_ov_c", 16'(out_valid), 16'd0);
    chk("t5_count1", 16'(fifo_count), 16'd1);
    step;
    chk("t5_count0", 16'(fifo_count), 16'd0);
    chk("t5_stray", 16'(err_stray), 16'd0);
    // reset in the middle of a packet
    rc_e2 = 1'b1;
    in_flit = 16'h8007; in_valid = 1'b1;
    step; in_flit = 16'h0071;
    step; in_flit = 16'h0072;
    chk("t6_hdr", out_flit, 16'h8007);
    step; in_flit = 16'h4073;
    chk("t6_body", out_flit, 16'h0071);
    step; in_valid = 1'b0;
    chk("t6_count_pre", 16'(fifo_count), 16'd2);
    chk("t6_e_pre", 16'({out_e1, out_e2}), 16'b01);
    #2 rst = 1'b0;
    #1;
    chk("t6_count_rst", 16'(fifo_count), 16'd0);
    chk("t6_e_rst", 16'({out_e1, out_e2}), 16'd0);
    chk("t6_ov_rst", 16'(out_valid), 16'd0);
    chk("t6_ready_rst", 16'(in_ready), 16'd1);
    step; rst = 1'b1;
    rc_e1 = 1'b1; rc_e2 = 1'b0;
    in_flit = 16'hC009; in_valid = 1'b1;
    step; in_valid = 1'b0;
    chk("t6_new_ov_idle", 16'(out_valid), 16'd0);
    step;
    chk("t6_new_ov", 16'(out_valid), 16'd1);
    chk("t6_new_flit", out_flit, 16'hC009);
    chk("t6_new_e", 16'({out_e1, out_e2}), 16'b10);
    step;
    chk("t6_new_end", 16'(out_valid), 16'd0);
    chk("t6_new_count", 16'(fifo_count), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
